axis_packet_arbiter_4to1: RTL and testbench
===========================================

AXIS_PACKET_ARBITER_4TO1 -- requirements
Module: axis_packet_arbiter_4to1

Interface
REQ-001 SHALL have parameter AXIS_BUS_WIDTH, default 64, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter AXIS_TID_WIDTH, default 1, tid width.
REQ-003 SHALL have parameter AXIS_TDEST_WIDTH, default 1, tdest width.
REQ-004 SHALL have parameter AXIS_TUSER_WIDTH, default 1, tuser width.
REQ-005 SHALL have parameter NUM_INPUTS, default 4, number of inputs in use (1..4).
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port aclk, input, 1, clock for all interfaces.
REQ-008 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port axis_in_#_tdata, input, AXIS_BUS_WIDTH, input data for # = 0..3.
REQ-010 SHALL have port axis_in_#_tkeep, input, AXIS_BUS_WIDTH/8, byte enables.
REQ-011 SHALL have port axis_in_#_tid, input, AXIS_TID_WIDTH, stream id.
REQ-012 SHALL have port axis_in_#_tdest, input, AXIS_TDEST_WIDTH, destination.
REQ-013 SHALL have port axis_in_#_tuser, input, AXIS_TUSER_WIDTH, sideband.
REQ-014 SHALL have ports axis_in_#_tlast and axis_in_#_tvalid, input, 1 each, end of packet and valid.
REQ-015 SHALL have port axis_in_#_tready, output, 1, input accept.
REQ-016 SHALL have ports axis_out_tdata, tkeep, tid, tdest, tuser, tlast and tvalid as outputs, with widths matching the inputs.
REQ-017 SHALL have port axis_out_tready, input, 1, downstream accept.

Function
REQ-018 SHALL hold a 2-state FSM: IDLE (no grant) and LOCKED (grant held by input g).
- In IDLE, with any enabled input's tvalid high, the FSM SHALL select g by round-robin starting at last_grant+1 (mod NUM_INPUTS).
- On the next cycle it SHALL enter LOCKED and set last_grant to g.
- In IDLE, all axis_in_#_tready SHALL be 0.
REQ-019 In LOCKED, axis_in_g_tready SHALL equal (!axis_out_tvalid || axis_out_tready); all other inputs' tready SHALL be 0.
REQ-020 A beat SHALL be accepted when axis_in_g_tvalid && axis_in_g_tready; an accepted beat with tlast=1 SHALL return the FSM to IDLE on the next cycle.
REQ-021 The output SHALL be a single register stage, loaded whenever (!axis_out_tvalid || axis_out_tready).
- In LOCKED, it SHALL load all fields of input g, with axis_out_tvalid set to the accept condition.
- In IDLE, it SHALL load axis_out_tvalid=0 and leave the data fields unchanged.
REQ-022 Latency SHALL be exactly 1 cycle from input acceptance to the beat appearing on the output.
- Full throughput SHALL be maintained within a packet while axis_out_tready=1.
- There SHALL be exactly one IDLE cycle between consecutive packets.
REQ-023 All fields SHALL pass through unmodified; tdest is not rewritten.
REQ-024 Inputs with index >= NUM_INPUTS SHALL never be granted and their tready SHALL be 0.
REQ-025 Grant SHALL be held across any number of input tvalid gaps until tlast is accepted; no timeout.
REQ-026 tvalid dropping on non-granted inputs SHALL have no effect; a tvalid held without tready SHALL be waited on indefinitely.
REQ-027 A packet whose first beat has tlast=1 SHALL occupy LOCKED for its accept cycle only.

Reset
REQ-028 While areset=1 on a rising edge, the block SHALL set FSM=IDLE, last_grant=NUM_INPUTS-1, axis_out_tvalid=0, and all output data fields to 0.
REQ-029 During reset cycles and the first cycle after reset, all axis_in_#_tready SHALL be 0.
REQ-030 Reset mid-packet SHALL discard the held output beat and the grant; after reset, arbitration SHALL restart with input 0 highest priority.

Verification
REQ-031 Single input: in_0 sends 3 beats (tdata 0xA,0xB,0xC; tlast on C) with out_tready=1 -> out shows A,B,C on 3 consecutive cycles, 1 cycle after each accept.
REQ-032 Round-robin: in_0..in_3 each hold a 2-beat packet from reset -> output packet order 0,1,2,3,0 with one idle cycle between packets.
REQ-033 Backpressure: out_tready=0 for 4 cycles mid-packet on in_1 -> out holds beat stable with tvalid=1, in_1_tready=0, no beat lost or duplicated.
REQ-034 Lock hold: in_2 granted, drops tvalid 5 cycles mid-packet while in_0 is valid -> in_0_tready stays 0 until in_2 tlast is accepted.
REQ-035 NUM_INPUTS=2 with in_3 valid -> in_3 is never granted, in_3_tready=0 throughout.
REQ-036 Reset mid-packet: areset pulsed during beat 2 of in_1 -> out_tvalid=0 next cycle; first grant after reset goes to in_0 if valid.

Source files
------------

// File: rtl/axis_packet_arbiter_4to1_if.sv
// AXI4-Stream link bundle used by the 4:1 packet arbiter: one data beat plus handshake.
// The master drives payload and tvalid, the slave drives tready.
interface axis_packet_arbiter_4to1_if #(
    parameter int AXIS_BUS_WIDTH   = 64,
    parameter int AXIS_TID_WIDTH   = 1,
    parameter int AXIS_TDEST_WIDTH = 1,
    parameter int AXIS_TUSER_WIDTH = 1
);
    logic [AXIS_BUS_WIDTH-1:0]   tdata;
    logic [AXIS_BUS_WIDTH/8-1:0] tkeep;
    logic [AXIS_TID_WIDTH-1:0]   tid;
    logic [AXIS_TDEST_WIDTH-1:0] tdest;
    logic [AXIS_TUSER_WIDTH-1:0] tuser;
    logic                        tlast;
    logic                        tvalid;
    logic                        tready;

    modport master (
        output tdata, tkeep, tid, tdest, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tid, tdest, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_packet_arbiter_4to1.sv
// Packet-level 4:1 AXI4-Stream arbiter: round-robin grant locked for a whole packet,
// single registered output stage with one-cycle latency.
module axis_packet_arbiter_4to1 #(
    parameter int AXIS_BUS_WIDTH   = 64,
    parameter int AXIS_TID_WIDTH   = 1,
    parameter int AXIS_TDEST_WIDTH = 1,
    parameter int AXIS_TUSER_WIDTH = 1,
    parameter int NUM_INPUTS       = 4
) (
    input  logic                            aclk,
    input  logic                            areset,
    axis_packet_arbiter_4to1_if.slave       axis_in_0,
    axis_packet_arbiter_4to1_if.slave       axis_in_1,
    axis_packet_arbiter_4to1_if.slave       axis_in_2,
    axis_packet_arbiter_4to1_if.slave       axis_in_3,
    axis_packet_arbiter_4to1_if.master      axis_out
);
    localparam int KEEP_W = AXIS_BUS_WIDTH / 8;
    localparam logic [3:0] EN_MASK = 4'((1 << NUM_INPUTS) - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    logic [AXIS_BUS_WIDTH-1:0]   in_tdata [4];
    logic [KEEP_W-1:0]           in_tkeep [4];
    logic [AXIS_TID_WIDTH-1:0]   in_tid   [4];
    logic [AXIS_TDEST_WIDTH-1:0] in_tdest [4];
    logic [AXIS_TUSER_WIDTH-1:0] in_tuser [4];
    logic [3:0]                  in_tlast;
    logic [3:0]                  in_tvalid;
    logic [3:0]                  tready_vec;

    state_t     state, state_next;
    logic [1:0] grant, grant_next;
    logic [1:0] last_grant, last_grant_next;
    logic       out_free;
    logic       accept;
    logic       rr_found;
    logic [1:0] rr_pick;
    logic [2:0] rr_idx;

    logic [AXIS_BUS_WIDTH-1:0]   tdata_p1;
    logic [KEEP_W-1:0]           tkeep_p1;
    logic [AXIS_TID_WIDTH-1:0]   tid_p1;
    logic [AXIS_TDEST_WIDTH-1:0] tdest_p1;
    logic [AXIS_TUSER_WIDTH-1:0] tuser_p1;
    logic                        tlast_p1;
    logic                        vld_p1;

    assign in_tdata[0] = axis_in_0.tdata;
    assign in_tdata[1] = axis_in_1.tdata;
    assign in_tdata[2] = axis_in_2.tdata;
    assign in_tdata[3] = axis_in_3.tdata;
    assign in_tkeep[0] = axis_in_0.tkeep;
    assign in_tkeep[1] = axis_in_1.tkeep;
    assign in_tkeep[2] = axis_in_2.tkeep;
    assign in_tkeep[3] = axis_in_3.tkeep;
    assign in_tid[0]   = axis_in_0.tid;
    assign in_tid[1]   = axis_in_1.tid;
    assign in_tid[2]   = axis_in_2.tid;
    assign in_tid[3]   = axis_in_3.tid;
    assign in_tdest[0] = axis_in_0.tdest;
    assign in_tdest[1] = axis_in_1.tdest;
    assign in_tdest[2] = axis_in_2.tdest;
    assign in_tdest[3] = axis_in_3.tdest;
    assign in_tuser[0] = axis_in_0.tuser;
    assign in_tuser[1] = axis_in_1.tuser;
    assign in_tuser[2] = axis_in_2.tuser;
    assign in_tuser[3] = axis_in_3.tuser;
    assign in_tlast    = {axis_in_3.tlast, axis_in_2.tlast, axis_in_1.tlast, axis_in_0.tlast};
    // Unused inputs are masked so they can never win arbitration.
    assign in_tvalid   = {axis_in_3.tvalid, axis_in_2.tvalid,
                          axis_in_1.tvalid, axis_in_0.tvalid} & EN_MASK;

    assign axis_in_0.tready = tready_vec[0] & EN_MASK[0];
    assign axis_in_1.tready = tready_vec[1] & EN_MASK[1];
    assign axis_in_2.tready = tready_vec[2] & EN_MASK[2];
    assign axis_in_3.tready = tready_vec[3] & EN_MASK[3];

    assign out_free = !vld_p1 || axis_out.tready;

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        accept          = 1'b0;
        tready_vec      = '0;
        rr_found        = 1'b0;
        rr_pick         = last_grant;
        rr_idx          = '0;

        // Search starts one past the previous winner and wraps modulo NUM_INPUTS.
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            rr_idx = {1'b0, last_grant} + 3'(k);
            if (rr_idx >= 3'(NUM_INPUTS))
                rr_idx = rr_idx - 3'(NUM_INPUTS);
            if (!rr_found && in_tvalid[rr_idx[1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx[1:0];
            end
        end

        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_next      = LOCKED;
                    grant_next      = rr_pick;
                    last_grant_next = rr_pick;
                end
            end
            LOCKED: begin
                tready_vec[grant] = out_free;
                accept            = in_tvalid[grant] && out_free;
                if (accept && in_tlast[grant])
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 2'(NUM_INPUTS - 1);
            vld_p1     <= 1'b0;
            tdata_p1   <= '0;
            tkeep_p1   <= '0;
            tid_p1     <= '0;
            tdest_p1   <= '0;
            tuser_p1   <= '0;
            tlast_p1   <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            // Output register stage (p1): refilled whenever downstream can take a beat.
            if (out_free) begin
                if (state == LOCKED) begin
                    tdata_p1 <= in_tdata[grant];
                    tkeep_p1 <= in_tkeep[grant];
                    tid_p1   <= in_tid[grant];
                    tdest_p1 <= in_tdest[grant];
                    tuser_p1 <= in_tuser[grant];
                    tlast_p1 <= in_tlast[grant];
                    vld_p1   <= accept;
                end else begin
                    vld_p1   <= 1'b0;
                end
            end
        end
    end

    assign axis_out.tdata  = tdata_p1;
    assign axis_out.tkeep  = tkeep_p1;
    assign axis_out.tid    = tid_p1;
    assign axis_out.tdest  = tdest_p1;
    assign axis_out.tuser  = tuser_p1;
    assign axis_out.tlast  = tlast_p1;
    assign axis_out.tvalid = vld_p1;
endmodule

// File: tb/tb_axis_packet_arbiter_4to1.sv
// Bench for the 4:1 packet arbiter: scoreboard-checked packet traffic on a 4-input
// instance plus a cycle table on a 2-input instance.
module tb_axis_packet_arbiter_4to1;
    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] data;
        logic [7:0]   keep;
        logic         id;
        logic         dest;
        logic         user;
        logic         last;
    } beat_t;

    typedef struct {
        logic         rst;
        logic [3:0]   vld;
        logic [3:0]   exp_rdy;
        logic         exp_ov;
        logic [W-1:0] exp_od;
    } vec_t;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic rst2 = 1'b1;
    logic out_ready = 1'b1;
    logic [3:0] in_valid = '0;
    logic [3:0] in_ready;
    logic [3:0] pkt_done = '0;
    logic [3:0] v2 = '0;
    logic [3:0] rdy2;
    beat_t drv [4];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    beat_t sb [$];
    int beat_cyc [$];
    int acc_cyc [$];
    vec_t tbl [11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_packet_arbiter_4to1_if #(.AXIS_BUS_WIDTH(W)) in_a [4] ();
    axis_packet_arbiter_4to1_if #(.AXIS_BUS_WIDTH(W)) out_a ();
    axis_packet_arbiter_4to1_if #(.AXIS_BUS_WIDTH(W)) in_b [4] ();
    axis_packet_arbiter_4to1_if #(.AXIS_BUS_WIDTH(W)) out_b ();

    for (genvar i = 0; i < 4; i++) begin : g_in
        assign in_a[i].tdata  = drv[i].data;
        assign in_a[i].tkeep  = drv[i].keep;
        assign in_a[i].tid    = drv[i].id;
        assign in_a[i].tdest  = drv[i].dest;
        assign in_a[i].tuser  = drv[i].user;
        assign in_a[i].tlast  = drv[i].last;
        assign in_a[i].tvalid = in_valid[i];
        assign in_ready[i]    = in_a[i].tready;
        assign in_b[i].tdata  = 64'hB0 + 64'(i);
        assign in_b[i].tkeep  = 8'hFF;
        assign in_b[i].tid    = 1'b0;
        assign in_b[i].tdest  = 1'b0;
        assign in_b[i].tuser  = 1'b0;
        assign in_b[i].tlast  = 1'b1;
        assign in_b[i].tvalid = v2[i];
        assign rdy2[i]        = in_b[i].tready;
    end
    assign out_a.tready = out_ready;
    assign out_b.tready = 1'b1;

    axis_packet_arbiter_4to1 #(.AXIS_BUS_WIDTH(W), .NUM_INPUTS(4)) dut (
        .aclk(clk), .areset(areset),
        .axis_in_0(in_a[0]), .axis_in_1(in_a[1]), .axis_in_2(in_a[2]), .axis_in_3(in_a[3]),
        .axis_out(out_a)
    );

    axis_packet_arbiter_4to1 #(.AXIS_BUS_WIDTH(W), .NUM_INPUTS(2)) dut2 (
        .aclk(clk), .areset(rst2),
        .axis_in_0(in_b[0]), .axis_in_1(in_b[1]), .axis_in_2(in_b[2]), .axis_in_3(in_b[3]),
        .axis_out(out_b)
    );

    function automatic beat_t mk_beat(input int port, input logic [W-1:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.keep = 8'hFF << port;
        b.id   = port[0];
        b.dest = port[1];
        b.user = d[0];
        b.last = last;
        return b;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int port, input int n, input logic [W-1:0] base);
        for (int b = 0; b < n; b++)
            sb.push_back(mk_beat(port, base + 64'(b), b == n - 1));
    endtask

    task automatic send_pkt(input int port, input int n, input logic [W-1:0] base,
                            input int gap_after, input int gap_len);
        for (int b = 0; b < n; b++) begin
            int t;
            bit got;
            if (b == gap_after && gap_len > 0) begin
                in_valid[port] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            drv[port] = mk_beat(port, base + 64'(b), b == n - 1);
            in_valid[port] = 1'b1;
            t = 0;
            got = 1'b0;
            while (!got && t < 200) begin
                @(negedge clk);
                if (in_ready[port]) begin
                    got = 1'b1;
                    acc_cyc.push_back(cyc);
                end
                @(posedge clk);
                #1;
                t++;
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drv_timeout port %0d: got no tready, expected tready within 200 cycles", port);
                in_valid[port] = 1'b0;
                return;
            end
        end
        in_valid[port] = 1'b0;
        pkt_done[port] = 1'b1;
    endtask

    task automatic do_reset();
        in_valid = '0;
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    // Output monitor: every transferred beat is matched against the scoreboard head.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (out_a.tvalid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got beat tdata %0h, expected no beat", out_a.tdata);
            end else begin
                e = sb.pop_front();
                beat_cyc.push_back(cyc);
                chk("sb_tdata", out_a.tdata, e.data);
                chk("sb_side", 64'({out_a.tkeep, out_a.tid, out_a.tdest, out_a.tuser, out_a.tlast}),
                    64'({e.keep, e.id, e.dest, e.user, e.last}));
            end
        end
    end

    initial begin
        int t0;
        int bad;
        int n;

        tbl[0]  = '{1'b1, 4'hF, 4'h0, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 4'hF, 4'h0, 1'b0, 64'h0};
        tbl[2]  = '{1'b0, 4'hF, 4'h0, 1'b0, 64'h0};
        tbl[3]  = '{1'b0, 4'hF, 4'h1, 1'b0, 64'h0};
        tbl[4]  = '{1'b0, 4'hF, 4'h0, 1'b1, 64'hB0};
        tbl[5]  = '{1'b0, 4'hF, 4'h2, 1'b0, 64'hB0};
        tbl[6]  = '{1'b0, 4'hF, 4'h0, 1'b1, 64'hB1};
        tbl[7]  = '{1'b0, 4'hF, 4'h1, 1'b0, 64'hB1};
        tbl[8]  = '{1'b0, 4'hF, 4'h0, 1'b1, 64'hB0};
        tbl[9]  = '{1'b0, 4'hF, 4'h2, 1'b0, 64'hB0};
        tbl[10] = '{1'b0, 4'hF, 4'h0, 1'b1, 64'hB1};

        // Reset state, with every input requesting during reset.
        for (int i = 0; i < 4; i++) drv[i] = mk_beat(i, 64'hEE, 1'b0);
        in_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_tvalid", 64'(out_a.tvalid), 64'h0);
        chk("rst_out_tdata", out_a.tdata, 64'h0);
        chk("rst_out_side", 64'({out_a.tkeep, out_a.tlast}), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        @(posedge clk);
        #1;
        in_valid = '0;
        areset = 1'b0;
        rst2 = 1'b0;

        // Single input, three beats, checked for per-beat latency.
        do_reset();
        t0 = cyc;
        acc_cyc.delete();
        beat_cyc.delete();
        sb.push_back(mk_beat(0, 64'hA, 1'b0));
        sb.push_back(mk_beat(0, 64'hB, 1'b0));
        sb.push_back(mk_beat(0, 64'hC, 1'b1));
        send_pkt(0, 3, 64'hA, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("single_beats", 64'(beat_cyc.size()), 64'd3);
        chk("single_first_cyc", 64'(beat_cyc[0]), 64'(t0 + 2));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("single_lat%0d", k), 64'(beat_cyc[k]), 64'(acc_cyc[k] + 1));
        end

        // Round robin: all inputs hold a 2-beat packet, in_0 queues a second one.
        do_reset();
        beat_cyc.delete();
        push_pkt(0, 2, 64'h00);
        push_pkt(1, 2, 64'h10);
        push_pkt(2, 2, 64'h20);
        push_pkt(3, 2, 64'h30);
        push_pkt(0, 2, 64'h40);
        fork
            begin
                send_pkt(0, 2, 64'h00, -1, 0);
                send_pkt(0, 2, 64'h40, -1, 0);
            end
            send_pkt(1, 2, 64'h10, -1, 0);
            send_pkt(2, 2, 64'h20, -1, 0);
            send_pkt(3, 2, 64'h30, -1, 0);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("rr_beats", 64'(beat_cyc.size()), 64'd10);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("rr_gap%0d", k), 64'(beat_cyc[k + 1] - beat_cyc[k]), (k % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Backpressure: downstream stalls 4 cycles while beat 1 of in_1 is held.
        do_reset();
        push_pkt(1, 5, 64'h100);
        fork
            send_pkt(1, 5, 64'h100, -1, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_tvalid", 64'(out_a.tvalid), 64'h1);
                    chk("bp_tdata", out_a.tdata, 64'h101);
                    chk("bp_in1_ready", 64'(in_ready[1]), 64'h0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Lock hold: in_2 pauses mid-packet while in_0 waits.
        do_reset();
        pkt_done = '0;
        push_pkt(2, 4, 64'h200);
        push_pkt(0, 2, 64'h300);
        bad = 0;
        n = 0;
        fork
            send_pkt(2, 4, 64'h200, 2, 5);
            begin
                repeat (2) @(posedge clk);
                #1;
                send_pkt(0, 2, 64'h300, -1, 0);
            end
            while (!pkt_done[2] && n < 300) begin
                @(negedge clk);
                if (!pkt_done[2] && in_ready[0]) bad++;
                n++;
            end
        join
        chk("lock_in0_ready_early", 64'(bad), 64'h0);
        repeat (3) @(posedge clk);
        #1;

        // Reset during beat 2 of an in_1 packet; the held beat must vanish.
        do_reset();
        sb.push_back(mk_beat(1, 64'h500, 1'b0));
        drv[1] = mk_beat(1, 64'h500, 1'b0);
        in_valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drv[1] = mk_beat(1, 64'h501, 1'b0);
        @(posedge clk);
        #1;
        drv[1] = mk_beat(1, 64'h502, 1'b0);
        out_ready = 1'b0;
        areset = 1'b1;
        @(negedge clk);
        chk("mid_held_tdata", out_a.tdata, 64'h501);
        @(posedge clk);
        #1;
        areset = 1'b0;
        out_ready = 1'b1;
        drv[0] = mk_beat(0, 64'h600, 1'b1);
        in_valid[0] = 1'b1;
        drv[1] = mk_beat(1, 64'h502, 1'b1);
        sb.push_back(mk_beat(0, 64'h600, 1'b1));
        sb.push_back(mk_beat(1, 64'h502, 1'b1));
        @(negedge clk);
        chk("mid_rst_tvalid", 64'(out_a.tvalid), 64'h0);
        chk("mid_rst_tdata", out_a.tdata, 64'h0);
        chk("mid_rst_ready", 64'(in_ready), 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_first_grant", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Two-input instance: in_2/in_3 request constantly but must never be served.
        for (int r = 0; r < 11; r++) begin
            rst2 = tbl[r].rst;
            v2 = tbl[r].vld;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 64'(rdy2), 64'(tbl[r].exp_rdy));
            chk($sformatf("tbl%0d_tvalid", r), 64'(out_b.tvalid), 64'(tbl[r].exp_ov));
            chk($sformatf("tbl%0d_tdata", r), out_b.tdata, tbl[r].exp_od);
            @(posedge clk);
            #1;
        end
        v2 = '0;

        chk("sb_drain", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
        $fatal(1);
    end
endmodule
